// File: rtl/rv32_ctrl_pkg.sv
// Shared control encodings for the RV32I sequencers: opcodes, FSM states, ALU/PC/writeback selects.
// Pure declarations; no timing or handshake behaviour of its own.
package rv32_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } mc_state_t;

    typedef enum logic [1:0] {
        ALU_PASS_B = 2'b00,
        ALU_SUB    = 2'b01,
        ALU_ADD    = 2'b10,
        ALU_FUNCT  = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'b00,
        PC_REL   = 2'b01,
        PC_JALR  = 2'b10
    } pc_src_t;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_LINK = 2'b10,
        WB_IMM  = 2'b11
    } wb_sel_t;

    function automatic logic is_legal_opcode(input logic [6:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OPIMM,
            OPC_OP, OPC_LOAD, OPC_STORE, OPC_BRANCH: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts cycles a memory request stays pending; flags timeout combinationally on the last allowed cycle.
// A ready in the timeout cycle suppresses the flag, so a late completion is never reported as an error.
module mc_wait_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic req_i,
    input  logic ready_i,
    output logic timeout_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || ready_i || !req_i) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_o = req_i && !ready_i && (cnt_q == LIMIT);

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB over one shared memory port, outputs Mealy on state/op_q/inputs.
// Stalls in FETCH/MEM until mem_ready; halts (sticky) on illegal opcode or memory timeout.
module mc_control_fsm
    import rv32_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic [1:0] alu_op,
    output logic       alu_src,
    output logic       reg_write,
    output logic [1:0] mem_out_sel,
    output logic       retire,
    output logic       halted,
    output logic       bus_err,
    output logic [2:0] state
);

    mc_state_t  state_q, state_d;
    logic [6:0] op_q;
    logic       bus_err_q, bus_err_d;
    logic       timeout;
    logic       cnt_clr;

    // Restart the wait count whenever a new request phase begins.
    assign cnt_clr = (state_d != state_q) && ((state_d == ST_FETCH) || (state_d == ST_MEM));

    mc_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) u_wait_timer (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .clr_i    (cnt_clr),
        .req_i    (mem_req),
        .ready_i  (mem_ready),
        .timeout_o(timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bus_err_q <= bus_err_d;
            if (state_q == ST_DECODE) begin
                op_q <= opcode;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        bus_err_d   = bus_err_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = PC_PLUS4;
        alu_op      = ALU_PASS_B;
        alu_src     = 1'b0;
        reg_write   = 1'b0;
        mem_out_sel = WB_ALU;
        retire      = 1'b0;
        halted      = 1'b0;

        case (state_q)
            ST_IDLE: state_d = ST_FETCH;

            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PC_PLUS4;
                    state_d  = ST_DECODE;
                end else if (timeout) begin
                    state_d   = ST_HALT;
                    bus_err_d = 1'b1;
                end
            end

            ST_DECODE: state_d = is_legal_opcode(opcode) ? ST_EXEC : ST_HALT;

            ST_EXEC: begin
                case (op_q)
                    OPC_OP: begin
                        alu_op  = ALU_FUNCT;
                        state_d = ST_WB;
                    end
                    OPC_OPIMM: begin
                        alu_op  = ALU_FUNCT;
                        alu_src = 1'b1;
                        state_d = ST_WB;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        alu_op  = ALU_ADD;
                        alu_src = 1'b1;
                        state_d = ST_MEM;
                    end
                    OPC_AUIPC, OPC_JAL, OPC_JALR: begin
                        alu_op  = ALU_ADD;
                        alu_src = 1'b1;
                        state_d = ST_WB;
                    end
                    OPC_LUI: state_d = ST_WB;
                    OPC_BRANCH: begin
                        alu_op = ALU_SUB;
                        retire = 1'b1;
                        if (branch_taken) begin
                            pc_write = 1'b1;
                            pc_src   = PC_REL;
                        end
                        state_d = ST_FETCH;
                    end
                    default: state_d = ST_HALT;
                endcase
            end

            ST_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (op_q == OPC_STORE);
                if (mem_ready) begin
                    if (op_q == OPC_STORE) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (timeout) begin
                    state_d   = ST_HALT;
                    bus_err_d = 1'b1;
                end
            end

            ST_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = ST_FETCH;
                case (op_q)
                    OPC_LOAD: mem_out_sel = WB_MEM;
                    OPC_LUI:  mem_out_sel = WB_IMM;
                    OPC_JAL: begin
                        mem_out_sel = WB_LINK;
                        pc_write    = 1'b1;
                        pc_src      = PC_REL;
                    end
                    OPC_JALR: begin
                        mem_out_sel = WB_LINK;
                        pc_write    = 1'b1;
                        pc_src      = PC_JALR;
                    end
                    default: mem_out_sel = WB_ALU;
                endcase
            end

            ST_HALT: halted = 1'b1;

            default: state_d = ST_HALT;
        endcase
    end

    assign bus_err = bus_err_q;
    assign state   = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed per-cycle vectors for mc_control_fsm (MEM_TIMEOUT = 4), plus hand-written reset corner cases.
module tb_mc_control_fsm;

    localparam logic [6:0] O_LUI = 7'b0110111;
    localparam logic [6:0] O_AUI = 7'b0010111;
    localparam logic [6:0] O_JAL = 7'b1101111;
    localparam logic [6:0] O_JLR = 7'b1100111;
    localparam logic [6:0] O_OP  = 7'b0110011;
    localparam logic [6:0] O_LD  = 7'b0000011;
    localparam logic [6:0] O_ST  = 7'b0100011;
    localparam logic [6:0] O_BR  = 7'b1100011;
    localparam logic [6:0] O_BAD = 7'b1110011;

    typedef struct packed {
        logic [2:0] st;
        logic       req;
        logic       we;
        logic       iord;
        logic       irw;
        logic       pcw;
        logic [1:0] pcs;
        logic [1:0] ao;
        logic       as;
        logic       rw;
        logic [1:0] ws;
        logic       ret;
        logic       hlt;
        logic       be;
    } out_t;

    typedef struct {
        logic [6:0] op;
        logic       rdy;
        logic       bt;
        out_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic       mem_ready = 1'b0;
    logic       branch_taken = 1'b0;
    logic       mem_req, mem_we, iord, ir_write, pc_write, alu_src, reg_write, retire, halted, bus_err;
    logic [1:0] pc_src, alu_op, mem_out_sel;
    logic [2:0] state;

    int checks = 0;
    int passed = 0;
    vec_t vq[$];

    mc_control_fsm #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_op(alu_op),
        .alu_src(alu_src), .reg_write(reg_write), .mem_out_sel(mem_out_sel),
        .retire(retire), .halted(halted), .bus_err(bus_err), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
        $fatal(1, "watchdog");
    end

    // Argument order: state, req, we, iord, ir_write, pc_write, pc_src, alu_op, alu_src, reg_write, wb_sel, retire, halted, bus_err
    function automatic out_t mk(input logic [2:0] st, input logic req, we, io, irw, pcw,
                                input logic [1:0] pcs, ao, input logic as, rw,
                                input logic [1:0] ws, input logic ret, hlt, be);
        out_t o;
        o = {st, req, we, io, irw, pcw, pcs, ao, as, rw, ws, ret, hlt, be};
        return o;
    endfunction

    function automatic out_t cur();
        out_t o;
        o = {state, mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_op,
             alu_src, reg_write, mem_out_sel, retire, halted, bus_err};
        return o;
    endfunction

    task automatic chk(input string name, input out_t act, input out_t exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    task automatic add(input logic [6:0] op, input logic rdy, input logic bt, input out_t e);
        vec_t v;
        v.op = op; v.rdy = rdy; v.bt = bt; v.exp = e;
        vq.push_back(v);
    endtask

    // Called just after a rising edge: drive, check mid-cycle, advance one edge.
    task automatic apply(input string name, input vec_t v);
        opcode = v.op; mem_ready = v.rdy; branch_taken = v.bt;
        @(negedge clk);
        chk(name, cur(), v.exp);
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input string tag);
        foreach (vq[i]) apply($sformatf("%s[%0d]", tag, i), vq[i]);
        vq.delete();
    endtask

    task automatic reset_pulse(input string name);
        rst_n = 1'b0;
        #1;
        chk(name, cur(), mk(0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0));
        #1;
        rst_n = 1'b1;
    endtask

    out_t IDL, FET, FSTL, DEC, EX_ADD, WB_ALU_E, MEMW, HLT_BE, HLT_IL;
    vec_t v;

    initial begin
        IDL      = mk(0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0);
        FET      = mk(1, 1,0,0,1,1, 0,0,0,0,0, 0,0,0);
        FSTL     = mk(1, 1,0,0,0,0, 0,0,0,0,0, 0,0,0);
        DEC      = mk(2, 0,0,0,0,0, 0,0,0,0,0, 0,0,0);
        EX_ADD   = mk(3, 0,0,0,0,0, 0,2,1,0,0, 0,0,0);
        WB_ALU_E = mk(5, 0,0,0,0,0, 0,0,0,1,0, 1,0,0);
        MEMW     = mk(4, 1,0,1,0,0, 0,0,0,0,0, 0,0,0);
        HLT_BE   = mk(6, 0,0,0,0,0, 0,0,0,0,0, 0,1,1);
        HLT_IL   = mk(6, 0,0,0,0,0, 0,0,0,0,0, 0,1,0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", cur(), IDL);
        rst_n = 1'b1;

        // OP with memory always ready
        add(O_OP, 1, 0, IDL);
        add(O_OP, 1, 0, FET);
        add(O_OP, 1, 0, DEC);
        add(O_OP, 1, 0, mk(3, 0,0,0,0,0, 0,3,0,0,0, 0,0,0));
        add(O_OP, 1, 0, WB_ALU_E);
        // LOAD with three stall cycles in MEM
        add(O_LD, 1, 0, FET);
        add(O_LD, 1, 0, DEC);
        add(O_LD, 1, 0, EX_ADD);
        for (int k = 0; k < 3; k++) add(O_LD, 0, 0, MEMW);
        add(O_LD, 1, 0, MEMW);
        add(O_LD, 1, 0, mk(5, 0,0,0,0,0, 0,0,0,1,1, 1,0,0));
        // BRANCH taken, then not taken
        add(O_BR, 1, 1, FET);
        add(O_BR, 1, 1, DEC);
        add(O_BR, 1, 1, mk(3, 0,0,0,0,1, 1,1,0,0,0, 1,0,0));
        add(O_BR, 1, 0, FET);
        add(O_BR, 1, 0, DEC);
        add(O_BR, 1, 0, mk(3, 0,0,0,0,0, 0,1,0,0,0, 1,0,0));
        // JALR
        add(O_JLR, 1, 0, FET);
        add(O_JLR, 1, 0, DEC);
        add(O_JLR, 1, 0, EX_ADD);
        add(O_JLR, 1, 0, mk(5, 0,0,0,0,1, 2,0,0,1,2, 1,0,0));
        // STORE completes from MEM directly
        add(O_ST, 1, 0, FET);
        add(O_ST, 1, 0, DEC);
        add(O_ST, 1, 0, EX_ADD);
        add(O_ST, 1, 0, mk(4, 1,1,1,0,0, 0,0,0,0,0, 1,0,0));
        // JAL
        add(O_JAL, 1, 0, FET);
        add(O_JAL, 1, 0, DEC);
        add(O_JAL, 1, 0, EX_ADD);
        add(O_JAL, 1, 0, mk(5, 0,0,0,0,1, 1,0,0,1,2, 1,0,0));
        // LUI
        add(O_LUI, 1, 0, FET);
        add(O_LUI, 1, 0, DEC);
        add(O_LUI, 1, 0, mk(3, 0,0,0,0,0, 0,0,0,0,0, 0,0,0));
        add(O_LUI, 1, 0, mk(5, 0,0,0,0,0, 0,0,0,1,3, 1,0,0));
        // AUIPC: ready arrives on the 4th fetch cycle, exactly at the timeout boundary
        for (int k = 0; k < 3; k++) add(O_AUI, 0, 0, FSTL);
        add(O_AUI, 1, 0, FET);
        add(O_AUI, 1, 0, DEC);
        add(O_AUI, 1, 0, EX_ADD);
        add(O_AUI, 1, 0, WB_ALU_E);
        // Fetch timeout: four request cycles, then sticky HALT with bus_err
        for (int k = 0; k < 4; k++) add(O_OP, 0, 0, FSTL);
        add(O_OP, 1, 0, HLT_BE);
        add(O_OP, 1, 0, HLT_BE);
        run_table("seqA");

        reset_pulse("rst_clears_halt");

        // Illegal opcode halts without bus_err
        add(O_BAD, 1, 0, IDL);
        add(O_BAD, 1, 0, FET);
        add(O_BAD, 1, 0, DEC);
        add(O_BAD, 1, 0, HLT_IL);
        add(O_BAD, 1, 0, HLT_IL);
        run_table("illegal");

        reset_pulse("rst_after_illegal");

        // Reset in the middle of a pending MEM request
        add(O_LD, 1, 0, IDL);
        add(O_LD, 1, 0, FET);
        add(O_LD, 1, 0, DEC);
        add(O_LD, 1, 0, EX_ADD);
        run_table("midmem_pre");
        mem_ready = 1'b0;
        #2;
        chk1("midmem_req_before_rst", mem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("midmem_req_dropped", mem_req, 1'b0);
        chk("midmem_rst_outputs", cur(), IDL);
        rst_n = 1'b1;
        add(O_LD, 1, 0, IDL);
        add(O_LD, 1, 0, FET);
        add(O_LD, 1, 0, DEC);
        run_table("midmem_post");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
